// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// debounces press and release on scan ticks, and reports each accepted key
// as a code on key together with a single-cycle trig pulse.
module keypad_scanner #(
  parameter int WIDTH    = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  output logic [WIDTH-1:0] key,
  output logic             trig
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_t;

  logic [3:0]       row_p0;
  logic [3:0]       rs;
  logic [DIV_W-1:0] div;
  logic             tick;

  state_t           state, state_nx;
  logic [1:0]       ci, ci_nx;
  logic [1:0]       ri, ri_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic [WIDTH-1:0] key_nx;
  logic             trig_nx;

  // Priority pick: the lowest-numbered row reading low wins.
  function automatic logic [1:0] lowest_low(input logic [3:0] r);
    logic [1:0] idx;
    if (!r[0])      idx = 2'd0;
    else if (!r[1]) idx = 2'd1;
    else if (!r[2]) idx = 2'd2;
    else            idx = 2'd3;
    return idx;
  endfunction

  assign tick    = (div == DIV_W'(SCAN_DIV - 1));
  assign cnt_inc = cnt + 1'b1;
  assign col     = ~(4'b0001 << ci);

  // Two-flop synchronizer for the asynchronous row lines; idle level is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_p0 <= 4'hF;
      rs     <= 4'hF;
    end else begin
      row_p0 <= row;
      rs     <= row_p0;
    end
  end

  // Free-running scan divider producing one tick every SCAN_DIV cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    div <= '0;
    else if (tick) div <= '0;
    else           div <= div + 1'b1;
  end

  // State register for the scan/debounce FSM and its outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_SCAN;
      ci    <= 2'd0;
      ri    <= 2'd0;
      cnt   <= '0;
      key   <= '0;
      trig  <= 1'b0;
    end else begin
      state <= state_nx;
      ci    <= ci_nx;
      ri    <= ri_nx;
      cnt   <= cnt_nx;
      key   <= key_nx;
      trig  <= trig_nx;
    end
  end

  // Next-state logic; everything holds except on tick cycles.
  always_comb begin
    state_nx = state;
    ci_nx    = ci;
    ri_nx    = ri;
    cnt_nx   = cnt;
    key_nx   = key;
    trig_nx  = 1'b0;
    if (tick) begin
      case (state)
        ST_SCAN: begin
          if (&rs) begin
            ci_nx = ci + 2'd1;
          end else begin
            ri_nx    = lowest_low(rs);
            cnt_nx   = '0;
            state_nx = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (!rs[ri]) begin
            cnt_nx = cnt_inc;
            if (cnt_inc == CNT_W'(DEBOUNCE)) begin
              state_nx = ST_PRESSED;
              key_nx   = WIDTH'({ri, ci});
              trig_nx  = 1'b1;
            end
          end else begin
            state_nx = ST_SCAN;
            ci_nx    = ci + 2'd1;
          end
        end
        ST_PRESSED: begin
          if (rs[ri]) begin
            cnt_nx   = '0;
            state_nx = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (rs[ri]) begin
            cnt_nx = cnt_inc;
            if (cnt_inc == CNT_W'(DEBOUNCE)) begin
              state_nx = ST_SCAN;
              ci_nx    = ci + 2'd1;
            end
          end else begin
            state_nx = ST_PRESSED;
          end
        end
        default: state_nx = ST_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a simulated 4x4 keypad matrix into keypad_scanner
// and checks scanning, debounce, hold, priority and reset behaviour.
module tb_keypad_scanner;

  localparam int WIDTH    = 6;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int LAT_MAX  = 2 + SCAN_DIV * (4 + DEBOUNCE);

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       row;
  logic [3:0]       col;
  logic [WIDTH-1:0] key;
  logic             trig;

  logic [15:0]      pressed = '0;   // bit r*4+c set = key at row r, column c held
  logic [WIDTH-1:0] model_key = '0;

  int checks    = 0;
  int failures  = 0;
  int trig_cnt  = 0;
  int trig_long = 0;
  int col_bad   = 0;
  int key_bad   = 0;
  logic             prev_trig = 1'b0;
  logic [WIDTH-1:0] prev_key  = '0;

  keypad_scanner #(
    .WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .key(key), .trig(trig)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a row reads low when a held key sits on the driven column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && col[c] === 1'b0) row[r] = 1'b0;
  end

  // Running observations of trig pulses, column drive and key stability.
  always @(negedge clk) begin
    if (trig === 1'b1) trig_cnt++;
    if (trig === 1'b1 && prev_trig === 1'b1) trig_long++;
    if (!$onehot(~col)) col_bad++;
    if (reset === 1'b1 && trig !== 1'b1 && key !== prev_key) key_bad++;
    prev_trig = trig;
    prev_key  = key;
  end

  // Expected code for keys held in one column: lowest row wins.
  function automatic logic [WIDTH-1:0] exp_code(input logic [15:0] p, input int c);
    for (int r = 0; r < 4; r++)
      if (p[r*4+c]) return WIDTH'(r * 4 + c);
    return '0;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for a trig pulse; lat counts from the first negedge with any row low.
  task automatic wait_trig(input int budget, output bit found, output int waited, output int lat);
    int start;
    bit done;
    start = -1; found = 1'b0; waited = 0; lat = 0; done = 1'b0;
    #1;
    if (row !== 4'hF) start = 0;
    while (!done && waited < budget) begin
      @(negedge clk);
      waited++;
      if (start < 0 && row !== 4'hF) start = waited;
      if (trig === 1'b1) begin
        found = 1'b1;
        lat   = (start < 0) ? waited : waited - start;
        done  = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    #3 reset = 1'b0;
    #1;
    checks++; if (col !== 4'b1110) begin failures++; $display("FAIL reset_col got=%b exp=%b", col, 4'b1110); end
    checks++; if (key !== '0) begin failures++; $display("FAIL reset_key got=%h exp=0", key); end
    checks++; if (trig !== 1'b0) begin failures++; $display("FAIL reset_trig got=%b exp=0", trig); end
    idle(3);
    reset = 1'b1;
    idle(2);
    checks++; if (key !== '0) begin failures++; $display("FAIL post_reset_key got=%h exp=0", key); end
    checks++; if (trig !== 1'b0) begin failures++; $display("FAIL post_reset_trig got=%b exp=0", trig); end
  endtask

  task automatic test_scan_wrap;
    logic [3:0] c0, one, exp;
    int n, i0;
    one = 4'b0001;
    c0 = col; n = 0;
    while (col === c0 && n < 20) begin @(negedge clk); n++; end
    checks++; if (col === c0) begin failures++; $display("FAIL wrap_sync got=%b exp=change", col); end
    i0 = 0;
    for (int i = 0; i < 4; i++) if (col[i] === 1'b0) i0 = i;
    for (int k = 1; k <= 20; k++) begin
      idle(SCAN_DIV);
      exp = ~(one << ((i0 + k) % 4));
      checks++; if (col !== exp) begin failures++; $display("FAIL wrap_col step=%0d got=%b exp=%b", k, col, exp); end
    end
  endtask

  task automatic test_single_press;
    int t0, waited, lat;
    bit found;
    logic [WIDTH-1:0] exp;
    t0 = trig_cnt;
    pressed[2*4+1] = 1'b1;
    exp = exp_code(pressed, 1);
    wait_trig(100, found, waited, lat);
    checks++; if (!found) begin failures++; $display("FAIL single_found got=0 exp=1"); end
    checks++; if (lat > LAT_MAX) begin failures++; $display("FAIL single_latency got=%0d exp<=%0d", lat, LAT_MAX); end
    checks++; if (key !== exp) begin failures++; $display("FAIL single_key got=%h exp=%h", key, exp); end
    model_key = exp;
    idle(40);
    pressed = '0;
    idle(40);
    checks++; if (trig_cnt - t0 != 1) begin failures++; $display("FAIL single_trigs got=%0d exp=1", trig_cnt - t0); end
    checks++; if (key !== model_key) begin failures++; $display("FAIL single_key_hold got=%h exp=%h", key, model_key); end
  endtask

  task automatic test_bounce;
    int t0, n;
    t0 = trig_cnt;
    n = 0;
    while (col === 4'b0111 && n < 40) begin @(negedge clk); n++; end
    while (col !== 4'b0111 && n < 40) begin @(negedge clk); n++; end
    checks++; if (col !== 4'b0111) begin failures++; $display("FAIL bounce_sync got=%b exp=%b", col, 4'b0111); end
    pressed[0*4+3] = 1'b1;
    idle(2 * SCAN_DIV);
    pressed = '0;
    idle(SCAN_DIV);
    checks++; if (col !== 4'b1110) begin failures++; $display("FAIL bounce_col got=%b exp=%b", col, 4'b1110); end
    idle(30);
    checks++; if (trig_cnt != t0) begin failures++; $display("FAIL bounce_trigs got=%0d exp=0", trig_cnt - t0); end
    checks++; if (key !== model_key) begin failures++; $display("FAIL bounce_key got=%h exp=%h", key, model_key); end
  endtask

  task automatic test_hold_glitch;
    int t0, waited, lat;
    bit found;
    logic [WIDTH-1:0] exp;
    t0 = trig_cnt;
    pressed[3*4+3] = 1'b1;
    exp = exp_code(pressed, 3);
    wait_trig(100, found, waited, lat);
    checks++; if (!found) begin failures++; $display("FAIL hold_found got=0 exp=1"); end
    checks++; if (key !== exp) begin failures++; $display("FAIL hold_key got=%h exp=%h", key, exp); end
    model_key = exp;
    idle(96);
    pressed[3*4+3] = 1'b0;
    idle(SCAN_DIV);
    pressed[3*4+3] = 1'b1;
    idle(100);
    checks++; if (trig_cnt - t0 != 1) begin failures++; $display("FAIL hold_trigs got=%0d exp=1", trig_cnt - t0); end
    pressed = '0;
    idle(40);
    checks++; if (trig_cnt - t0 != 1) begin failures++; $display("FAIL hold_release_trigs got=%0d exp=1", trig_cnt - t0); end
    checks++; if (key !== model_key) begin failures++; $display("FAIL hold_key_after got=%h exp=%h", key, model_key); end
  endtask

  task automatic test_simultaneous;
    int t0, waited, lat;
    bit found;
    logic [WIDTH-1:0] exp;
    t0 = trig_cnt;
    pressed[1*4+0] = 1'b1;
    pressed[3*4+0] = 1'b1;
    exp = exp_code(pressed, 0);
    wait_trig(100, found, waited, lat);
    checks++; if (!found) begin failures++; $display("FAIL simul_found got=0 exp=1"); end
    checks++; if (key !== exp) begin failures++; $display("FAIL simul_key got=%h exp=%h", key, exp); end
    model_key = exp;
    idle(20);
    pressed = '0;
    idle(40);
    checks++; if (trig_cnt - t0 != 1) begin failures++; $display("FAIL simul_trigs got=%0d exp=1", trig_cnt - t0); end
  endtask

  task automatic test_reset_mid_debounce;
    int t0, n, waited, lat;
    bit found;
    logic [WIDTH-1:0] exp;
    t0 = trig_cnt;
    pressed[2*4+1] = 1'b1;
    exp = exp_code(pressed, 1);
    n = 0;
    while (row === 4'hF && n < 40) begin @(negedge clk); n++; end
    checks++; if (row === 4'hF) begin failures++; $display("FAIL rstdb_row got=%b exp=low", row); end
    idle(2 * SCAN_DIV);
    #2 reset = 1'b0;
    #1;
    checks++; if (col !== 4'b1110) begin failures++; $display("FAIL rstdb_col got=%b exp=%b", col, 4'b1110); end
    checks++; if (key !== '0) begin failures++; $display("FAIL rstdb_key got=%h exp=0", key); end
    checks++; if (trig !== 1'b0) begin failures++; $display("FAIL rstdb_trig got=%b exp=0", trig); end
    model_key = '0;
    idle(3);
    reset = 1'b1;
    checks++; if (trig_cnt != t0) begin failures++; $display("FAIL rstdb_no_trig got=%0d exp=0", trig_cnt - t0); end
    wait_trig(100, found, waited, lat);
    checks++; if (!found) begin failures++; $display("FAIL rstdb_found got=0 exp=1"); end
    checks++; if (waited < SCAN_DIV * (DEBOUNCE + 1)) begin failures++; $display("FAIL rstdb_full_debounce got=%0d exp>=%0d", waited, SCAN_DIV * (DEBOUNCE + 1)); end
    checks++; if (key !== exp) begin failures++; $display("FAIL rstdb_key_after got=%h exp=%h", key, exp); end
    model_key = exp;
    idle(10);
    pressed = '0;
    idle(40);
    checks++; if (trig_cnt - t0 != 1) begin failures++; $display("FAIL rstdb_trigs got=%0d exp=1", trig_cnt - t0); end
  endtask

  task automatic test_random;
    int t0, c, m, waited, lat;
    bit found;
    logic [WIDTH-1:0] exp;
    for (int it = 0; it < 8; it++) begin
      t0 = trig_cnt;
      c = $urandom_range(0, 3);
      m = $urandom_range(1, 15);
      idle($urandom_range(0, 7));
      for (int r = 0; r < 4; r++) if (m[r]) pressed[r*4+c] = 1'b1;
      exp = exp_code(pressed, c);
      wait_trig(100, found, waited, lat);
      checks++; if (!found) begin failures++; $display("FAIL rand_found it=%0d got=0 exp=1", it); end
      checks++; if (lat > LAT_MAX) begin failures++; $display("FAIL rand_latency it=%0d got=%0d exp<=%0d", it, lat, LAT_MAX); end
      checks++; if (key !== exp) begin failures++; $display("FAIL rand_key it=%0d got=%h exp=%h", it, key, exp); end
      model_key = exp;
      idle($urandom_range(0, 40));
      pressed = '0;
      idle(40);
      checks++; if (trig_cnt - t0 != 1) begin failures++; $display("FAIL rand_trigs it=%0d got=%0d exp=1", it, trig_cnt - t0); end
    end
  endtask

  task automatic test_invariants;
    checks++; if (col_bad != 0) begin failures++; $display("FAIL col_onehot got=%0d exp=0", col_bad); end
    checks++; if (key_bad != 0) begin failures++; $display("FAIL key_stable got=%0d exp=0", key_bad); end
    checks++; if (trig_long != 0) begin failures++; $display("FAIL trig_width got=%0d exp=0", trig_long); end
  endtask

  initial begin
    test_reset;
    test_scan_wrap;
    test_single_press;
    test_bounce;
    test_hold_glitch;
    test_simultaneous;
    test_reset_mid_debounce;
    test_random;
    test_invariants;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter WIDTH, default 4, key code output width; WIDTH >= 4, bits above bit 3 always 0.
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clk cycles per scan tick; legal range >= 2.
REQ-003 SHALL have parameter DEBOUNCE, default 4, consecutive scan ticks needed to accept a press or a release; legal range >= 1.
REQ-004 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port row  input  4  keypad row sense, active-low, asynchronous to clk.
REQ-007 SHALL have port col  output  4  keypad column drive, active-low, exactly one bit low at all times.
REQ-008 SHALL have port key  output  WIDTH  code of the last accepted key.
REQ-009 SHALL have port trig  output  1  one-clk pulse per accepted press; feeds the digit shift register's trig and in (key) inputs.

Function
REQ-010 SHALL pass row through a 2-flop synchronizer; all decisions use the synchronized value (rs).
REQ-011 SHALL run a free-running divider 0..SCAN_DIV-1 and assert an internal tick for one cycle when the divider equals SCAN_DIV-1.
REQ-012 SHALL implement states SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-013 SHALL, in SCAN on a tick with all rs bits high, advance the column index ci by 1 mod 4 (3 wraps to 0) and drive col = ~(1<<ci).
REQ-014 SHALL, in SCAN on a tick with any rs bit low, latch ri = the lowest-numbered low row, hold ci, clear the stability count, and enter DEBOUNCE.
REQ-015 SHALL, in DEBOUNCE on each tick, increment the stability count if rs[ri] is low; when the count reaches DEBOUNCE, enter PRESSED.
REQ-016 SHALL, in DEBOUNCE on a tick with rs[ri] high, return to SCAN and advance ci without asserting trig.
REQ-017 SHALL, on entry to PRESSED, load key = ri*4 + ci (zero-extended) and assert trig high for exactly one clk cycle in that same cycle.
REQ-018 SHALL, in PRESSED, hold ci and emit no further trig while rs[ri] stays low; on a tick with rs[ri] high, clear the count and enter RELEASE.
REQ-019 SHALL, in RELEASE on each tick, increment the count if rs[ri] is high; when the count reaches DEBOUNCE, enter SCAN and advance ci.
REQ-020 SHALL, in RELEASE on a tick with rs[ri] low, return to PRESSED without asserting trig.
REQ-021 SHALL ignore rows other than ri, and all other key presses, while in DEBOUNCE, PRESSED or RELEASE.
REQ-022 SHALL hold key stable between accepted presses; key changes only in the trig cycle.
REQ-023 SHALL only evaluate state transitions on tick cycles; non-tick cycles hold state, ci and count.
REQ-024 SHALL set worst-case press latency (row low to trig) to at most 2 + SCAN_DIV*(4+DEBOUNCE) clk cycles.

Reset
REQ-025 SHALL, while reset is low, asynchronously force state=SCAN, ci=0, col=4'b1110, key=0, trig=0, divider=0, count=0, synchronizer flops=1.
REQ-026 SHALL, when reset asserts mid-debounce or mid-press, discard the pending key and emit no trig.
REQ-027 SHALL, after reset deasserts, require a full new debounce for any key already held before trig is asserted.

Verification (SCAN_DIV=4, DEBOUNCE=3)
REQ-028 SHALL cover a single press: row[2] held low whenever col=4'b1101 -> exactly one trig, key=4'h9, at most 2+4*7 clk cycles after the first low sample.
REQ-029 SHALL cover bounce: row[0] low on 2 ticks then high at col 3 -> no trig, key unchanged, ci advances to 0.
REQ-030 SHALL cover hold: key 4'hF held for 200 clk cycles -> exactly one trig; a 1-tick release glitch mid-hold -> still exactly one trig.
REQ-031 SHALL cover simultaneous rows: row[1] and row[3] low at col 0 -> key=4'h4 (lowest row wins).
REQ-032 SHALL cover reset mid-DEBOUNCE: reset pulsed low -> col=4'b1110, key=0, trig=0 immediately; the held key then yields one trig only after full debounce.
REQ-033 SHALL cover scan wrap: no keys for 20 ticks -> col cycles 1110,1101,1011,0111,1110 with exactly one low bit at every clk.
